// File: rtl/surf4_mmcm_seq_if.sv
// MMCM control/status bundle between the lock sequencer and the MMCM primitive.
interface surf4_mmcm_seq_if;
  logic mmcm_locked_i;
  logic mmcm_clkinstopped_i;
  logic mmcm_rst_o;
  logic mmcm_pwrdwn_o;
  logic mmcm_clkinsel_o;

  modport master (
    input  mmcm_locked_i,
    input  mmcm_clkinstopped_i,
    output mmcm_rst_o,
    output mmcm_pwrdwn_o,
    output mmcm_clkinsel_o
  );

  modport slave (
    output mmcm_locked_i,
    output mmcm_clkinstopped_i,
    input  mmcm_rst_o,
    input  mmcm_pwrdwn_o,
    input  mmcm_clkinsel_o
  );
endinterface

// File: rtl/surf4_mmcm_seq.sv
// MMCM reset / lock sequencer with input-clock selection, power-down and fault handling.
// Optional automatic clock-input fallback on failure: define SURF4_MMCM_FALLBACK_EN.
module surf4_mmcm_seq #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 100000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sel_req_i,
  input  logic                    switch_i,
  input  logic                    pwrdn_req_i,
  surf4_mmcm_seq_if.master        mmcm,
  output logic                    locked_o,
  output logic                    busy_o,
  output logic                    lock_lost_o,
  output logic                    timeout_o,
  output logic                    fallback_o,
  output logic [2:0]              state_o
);

  localparam int unsigned CNT_W = 20;
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RUN       = 3'd2,
    ST_PWRDN     = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lk_meta_q, lk_q, cs_meta_q, cs_q;
  logic             lost_q, lost_d;
  logic             timeout_q, timeout_d;
  logic             mmcm_rst_q, mmcm_rst_d;
  logic             pwrdwn_q, pwrdwn_d;
  logic             locked_q, locked_d;
  logic             busy_q, busy_d;
  logic             fail_c, fail_timeout_c;
`ifdef SURF4_MMCM_FALLBACK_EN
  logic             flag_q, flag_d;
  logic             fallback_q, fallback_d;
`endif

  // Next-state, counter and event decisions
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    cnt_d          = cnt_q;
    lost_d         = 1'b0;
    timeout_d      = 1'b0;
    fail_c         = 1'b0;
    fail_timeout_c = 1'b0;
`ifdef SURF4_MMCM_FALLBACK_EN
    flag_d         = flag_q;
    fallback_d     = 1'b0;
`endif

    if (pwrdn_req_i) begin
      state_d = ST_PWRDN;
      cnt_d   = '0;
    end else if (state_q == ST_PWRDN) begin
      state_d = ST_RESET;
      cnt_d   = '0;
    end else if (switch_i) begin
      sel_d   = sel_req_i;
      state_d = ST_RESET;
      cnt_d   = '0;
`ifdef SURF4_MMCM_FALLBACK_EN
      flag_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lk_q && !cs_q) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (cnt_q == LOCK_LAST) begin
            timeout_d      = 1'b1;
            fail_c         = 1'b1;
            fail_timeout_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lk_q || cs_q) begin
            lost_d = 1'b1;
            fail_c = 1'b1;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase
    end

    // The first failure after a switch retries on the other input when fallback is built in
    if (fail_c) begin
      cnt_d = '0;
`ifdef SURF4_MMCM_FALLBACK_EN
      if (!flag_q) begin
        sel_d      = ~sel_q;
        flag_d     = 1'b1;
        fallback_d = 1'b1;
        state_d    = ST_RESET;
      end else
`endif
      begin
        state_d = fail_timeout_c ? ST_FAULT : ST_RESET;
      end
    end

    mmcm_rst_d = (state_d != ST_WAIT_LOCK) && (state_d != ST_RUN);
    pwrdwn_d   = (state_d == ST_PWRDN);
    locked_d   = (state_d == ST_RUN);
    busy_d     = (state_d == ST_RESET) || (state_d == ST_WAIT_LOCK);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RESET;
      sel_q      <= 1'b1;
      cnt_q      <= '0;
      lk_meta_q  <= 1'b0;
      lk_q       <= 1'b0;
      cs_meta_q  <= 1'b0;
      cs_q       <= 1'b0;
      lost_q     <= 1'b0;
      timeout_q  <= 1'b0;
      mmcm_rst_q <= 1'b1;
      pwrdwn_q   <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b1;
`ifdef SURF4_MMCM_FALLBACK_EN
      flag_q     <= 1'b0;
      fallback_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      lk_meta_q  <= mmcm.mmcm_locked_i;
      lk_q       <= lk_meta_q;
      cs_meta_q  <= mmcm.mmcm_clkinstopped_i;
      cs_q       <= cs_meta_q;
      lost_q     <= lost_d;
      timeout_q  <= timeout_d;
      mmcm_rst_q <= mmcm_rst_d;
      pwrdwn_q   <= pwrdwn_d;
      locked_q   <= locked_d;
      busy_q     <= busy_d;
`ifdef SURF4_MMCM_FALLBACK_EN
      flag_q     <= flag_d;
      fallback_q <= fallback_d;
`endif
    end
  end

  assign mmcm.mmcm_rst_o      = mmcm_rst_q;
  assign mmcm.mmcm_pwrdwn_o   = pwrdwn_q;
  assign mmcm.mmcm_clkinsel_o = sel_q;
  assign locked_o             = locked_q;
  assign busy_o               = busy_q;
  assign lock_lost_o          = lost_q;
  assign timeout_o            = timeout_q;
  assign state_o              = state_q;
`ifdef SURF4_MMCM_FALLBACK_EN
  assign fallback_o           = fallback_q;
`else
  assign fallback_o           = 1'b0;
`endif

endmodule
